// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcodes, ALU codes, FSM states and the decoded-control bundle
// for the accumulator-ISA control sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_MEM,
    S_HALT,
    S_FAULT
  } state_e;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_SLL = 4'h2;
  localparam logic [3:0] ALU_SRL = 4'h3;
  localparam logic [3:0] ALU_SUB = 4'h4;
  localparam logic [3:0] ALU_SLT = 4'h5;
  localparam logic [3:0] ALU_ABS = 4'h6;
  localparam logic [3:0] ALU_SEQ = 4'h7;
  localparam logic [3:0] ALU_SET = 4'h8;
  localparam logic [3:0] ALU_TBA = 4'h9;

  localparam logic [4:0] OP_SLL   = 5'b11100;
  localparam logic [4:0] OP_SRL   = 5'b11101;
  localparam logic [4:0] OP_BRF   = 5'b11110;
  localparam logic [4:0] OP_SUB   = 5'b11111;
  localparam logic [4:0] OP_SLT   = 5'b10000;
  localparam logic [4:0] OP_HALT  = 5'b10001;
  localparam logic [4:0] OP_LOAD  = 5'b10010;
  localparam logic [4:0] OP_STORE = 5'b10011;
  localparam logic [4:0] OP_ABS   = 5'b10100;
  localparam logic [4:0] OP_SEQ   = 5'b10101;
  localparam logic [4:0] OP_BRB   = 5'b10110;
  localparam logic [4:0] OP_TBA   = 5'b10111;

  typedef struct packed {
    logic [3:0] alu;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] wa;
    logic [4:0] imm;
    logic       regwrite;
    logic       wdc;
    logic       cbwrite;
    logic       memread;
    logic       memwrite;
    logic       brf;
    logic       brb;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: pure combinational instruction decode into ctrl_t.
// brf/brb here mark branch kind only; the sequencer gates them with CB.
import ctrl_pkg::*;

module ctrl_decode #(
  parameter int ACC_REG = 7,
  parameter int SUB_RS  = 2,
  parameter int SUB_RT  = 5,
  parameter int CMP_RS  = 6
) (
  input  logic [7:0] instr_i,
  output ctrl_t      ctrl_o,
  output logic       is_branch_o,
  output logic       is_halt_o,
  output logic       is_mem_o
);

  logic [4:0] op;
  logic [2:0] lo;
  logic [2:0] acc;

  assign op  = instr_i[7:3];
  assign lo  = instr_i[2:0];
  assign acc = 3'(ACC_REG);

  // opcode classes are disjoint and cover all 32 patterns
  always_comb begin
    ctrl_o      = '0;
    is_branch_o = 1'b0;
    is_halt_o   = 1'b0;
    is_mem_o    = 1'b0;
    unique case (1'b1)
      op[4] == 1'b0: begin
        ctrl_o.alu      = op[3] ? ALU_ADD : ALU_AND;
        ctrl_o.wa       = instr_i[5:3];
        ctrl_o.rs       = lo;
        ctrl_o.rt       = acc;
        ctrl_o.regwrite = 1'b1;
      end
      op[4:2] == 3'b110: begin
        ctrl_o.alu      = ALU_SET;
        ctrl_o.imm      = instr_i[4:0];
        ctrl_o.wa       = acc;
        ctrl_o.regwrite = 1'b1;
      end
      op == OP_SLL, op == OP_SRL: begin
        ctrl_o.alu      = op[0] ? ALU_SRL : ALU_SLL;
        ctrl_o.rs       = lo;
        ctrl_o.wa       = lo;
        ctrl_o.rt       = acc;
        ctrl_o.regwrite = 1'b1;
      end
      op == OP_BRF, op == OP_BRB: begin
        ctrl_o.alu  = ALU_ADD;
        ctrl_o.rs   = lo;
        ctrl_o.brf  = (op == OP_BRF);
        ctrl_o.brb  = (op == OP_BRB);
        is_branch_o = 1'b1;
      end
      op == OP_SUB: begin
        ctrl_o.alu      = ALU_SUB;
        ctrl_o.rs       = 3'(SUB_RS);
        ctrl_o.rt       = 3'(SUB_RT);
        ctrl_o.wa       = lo;
        ctrl_o.regwrite = 1'b1;
      end
      op == OP_SLT: begin
        ctrl_o.alu     = ALU_SLT;
        ctrl_o.rs      = 3'(CMP_RS);
        ctrl_o.rt      = acc;
        ctrl_o.cbwrite = 1'b1;
      end
      op == OP_HALT: is_halt_o = 1'b1;
      op == OP_LOAD: begin
        ctrl_o.alu     = ALU_ADD;
        ctrl_o.wa      = lo;
        ctrl_o.rt      = acc;
        ctrl_o.memread = 1'b1;
        ctrl_o.wdc     = 1'b1;
        is_mem_o       = 1'b1;
      end
      op == OP_STORE: begin
        ctrl_o.alu      = ALU_ADD;
        ctrl_o.rs       = lo;
        ctrl_o.rt       = acc;
        ctrl_o.memwrite = 1'b1;
        is_mem_o        = 1'b1;
      end
      op == OP_ABS: begin
        ctrl_o.alu      = ALU_ABS;
        ctrl_o.rs       = lo;
        ctrl_o.wa       = lo;
        ctrl_o.regwrite = 1'b1;
      end
      op == OP_SEQ: begin
        ctrl_o.alu     = ALU_SEQ;
        ctrl_o.rs      = lo;
        ctrl_o.rt      = acc;
        ctrl_o.cbwrite = 1'b1;
      end
      op == OP_TBA: begin
        ctrl_o.alu      = ALU_TBA;
        ctrl_o.rs       = lo;
        ctrl_o.rt       = acc;
        ctrl_o.wa       = acc;
        ctrl_o.regwrite = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: handshaked multi-cycle control sequencer with CB, mem stall,
// halt and timeout fault. CTRL_PERF_EN adds retired_o/stall_o counters.
import ctrl_pkg::*;

module ctrl_sequencer #(
  parameter int   ACC_REG     = 7,
  parameter int   SUB_RS      = 2,
  parameter int   SUB_RT      = 5,
  parameter int   CMP_RS      = 6,
  parameter int   MEM_TIMEOUT = 16,
  parameter logic CB_RST      = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [7:0] instr_i,
  input  logic       instr_valid_i,
  output logic       instr_ready_o,
  input  logic       alu_flag_i,
  input  logic       mem_ready_i,
  output logic       ctrl_valid_o,
  output logic [3:0] alucontrol_o,
  output logic [2:0] rs_addr_o,
  output logic [2:0] rt_addr_o,
  output logic [2:0] write_addr_o,
  output logic [4:0] immediate_o,
  output logic       regwrite_o,
  output logic       write_data_control_o,
  output logic       cbwrite_o,
  output logic       memread_o,
  output logic       memwrite_o,
  output logic       branchf_o,
  output logic       branchb_o,
  output logic       cb_o,
  output logic       done_o,
  output logic       fault_o
`ifdef CTRL_PERF_EN
  ,
  output logic [15:0] retired_o,
  output logic [15:0] stall_o
`endif
);

  ctrl_t       dec;
  logic        dec_br;
  logic        dec_halt;
  logic        dec_mem;

  state_e      state_q, state_d;
  ctrl_t       out_q, out_d;
  logic        valid_q, valid_d;
  logic        cb_q, cb_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [15:0] tmo_q, tmo_d;
  logic        interlock;
  logic        accept;
  logic        tmo_hit;

  ctrl_decode #(
    .ACC_REG (ACC_REG),
    .SUB_RS  (SUB_RS),
    .SUB_RT  (SUB_RT),
    .CMP_RS  (CMP_RS)
  ) u_decode (
    .instr_i     (instr_i),
    .ctrl_o      (dec),
    .is_branch_o (dec_br),
    .is_halt_o   (dec_halt),
    .is_mem_o    (dec_mem)
  );

  // a branch must not sample CB while a CB writer is still on the outputs
  assign interlock     = instr_valid_i & dec_br & out_q.cbwrite;
  assign instr_ready_o = (state_q == S_RUN) & ~interlock;
  assign accept        = instr_valid_i & instr_ready_o;
  assign tmo_hit       = (MEM_TIMEOUT != 0) &&
                         (tmo_q == 16'(MEM_TIMEOUT - 1));

  // next-state and next-output logic; outputs default to zero every cycle
  always_comb begin
    state_d = state_q;
    out_d   = '0;
    valid_d = 1'b0;
    cb_d    = cb_q;
    done_d  = done_q;
    fault_d = fault_q;
    tmo_d   = '0;
    if (out_q.cbwrite) cb_d = alu_flag_i;
    unique case (state_q)
      S_IDLE: if (start_i) state_d = S_RUN;
      S_RUN: begin
        if (accept) begin
          valid_d   = 1'b1;
          out_d     = dec;
          out_d.brf = dec.brf & cb_q;
          out_d.brb = dec.brb & cb_q;
          if (dec_mem) begin
            state_d = S_MEM;
          end else if (dec_halt) begin
            state_d = S_HALT;
            done_d  = 1'b1;
          end
        end
      end
      S_MEM: begin
        if (mem_ready_i) begin
          state_d = S_RUN;
          if (out_q.memread) begin
            valid_d        = 1'b1;
            out_d          = out_q;
            out_d.memread  = 1'b0;
            out_d.regwrite = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          out_d   = out_q;
          tmo_d   = tmo_q + 16'd1;
        end
      end
      S_HALT: begin
        if (start_i) begin
          state_d = S_RUN;
          done_d  = 1'b0;
        end
      end
      S_FAULT: ;
      default: state_d = S_IDLE;
    endcase
  end

  // single state/output register bank; reset aborts any memory access
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      valid_q <= 1'b0;
      cb_q    <= CB_RST;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      cb_q    <= cb_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      tmo_q   <= tmo_d;
    end
  end

  assign ctrl_valid_o         = valid_q;
  assign alucontrol_o         = out_q.alu;
  assign rs_addr_o            = out_q.rs;
  assign rt_addr_o            = out_q.rt;
  assign write_addr_o         = out_q.wa;
  assign immediate_o          = out_q.imm;
  assign regwrite_o           = out_q.regwrite;
  assign write_data_control_o = out_q.wdc;
  assign cbwrite_o            = out_q.cbwrite;
  assign memread_o            = out_q.memread;
  assign memwrite_o           = out_q.memwrite;
  assign branchf_o            = out_q.brf;
  assign branchb_o            = out_q.brb;
  assign cb_o                 = cb_q;
  assign done_o               = done_q;
  assign fault_o              = fault_q;

`ifdef CTRL_PERF_EN
  logic [15:0] ret_q, ret_d;
  logic [15:0] stl_q, stl_d;
  logic        retire;
  logic        stall;

  assign retire = (accept & ~dec_mem) |
                  ((state_q == S_MEM) & mem_ready_i);
  assign stall  = ((state_q == S_RUN) | (state_q == S_MEM)) &
                  instr_valid_i & ~instr_ready_o;

  // saturating retire and stall counters
  always_comb begin
    ret_d = ret_q;
    stl_d = stl_q;
    if (retire && ret_q != 16'hFFFF) ret_d = ret_q + 16'd1;
    if (stall && stl_q != 16'hFFFF) stl_d = stl_q + 16'd1;
  end

  // counter registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ret_q <= '0;
      stl_q <= '0;
    end else begin
      ret_q <= ret_d;
      stl_q <= stl_d;
    end
  end

  assign retired_o = ret_q;
  assign stall_o   = stl_q;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed stimulus with a queue scoreboard; a negedge
// monitor pops one expected control vector per ctrl_valid_o cycle.
module tb_ctrl_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic [7:0] instr_i;
  logic       instr_valid_i;
  logic       instr_ready_o;
  logic       alu_flag_i;
  logic       mem_ready_i;
  logic       ctrl_valid_o;
  logic [3:0] alucontrol_o;
  logic [2:0] rs_addr_o;
  logic [2:0] rt_addr_o;
  logic [2:0] write_addr_o;
  logic [4:0] immediate_o;
  logic       regwrite_o;
  logic       write_data_control_o;
  logic       cbwrite_o;
  logic       memread_o;
  logic       memwrite_o;
  logic       branchf_o;
  logic       branchb_o;
  logic       cb_o;
  logic       done_o;
  logic       fault_o;
`ifdef CTRL_PERF_EN
  logic [15:0] retired_o;
  logic [15:0] stall_o;
`endif

  ctrl_sequencer dut (
    .clk_i                (clk),
    .rst_n_i              (rst_n),
    .start_i              (start_i),
    .instr_i              (instr_i),
    .instr_valid_i        (instr_valid_i),
    .instr_ready_o        (instr_ready_o),
    .alu_flag_i           (alu_flag_i),
    .mem_ready_i          (mem_ready_i),
    .ctrl_valid_o         (ctrl_valid_o),
    .alucontrol_o         (alucontrol_o),
    .rs_addr_o            (rs_addr_o),
    .rt_addr_o            (rt_addr_o),
    .write_addr_o         (write_addr_o),
    .immediate_o          (immediate_o),
    .regwrite_o           (regwrite_o),
    .write_data_control_o (write_data_control_o),
    .cbwrite_o            (cbwrite_o),
    .memread_o            (memread_o),
    .memwrite_o           (memwrite_o),
    .branchf_o            (branchf_o),
    .branchb_o            (branchb_o),
    .cb_o                 (cb_o),
    .done_o               (done_o),
    .fault_o              (fault_o)
`ifdef CTRL_PERF_EN
    ,
    .retired_o            (retired_o),
    .stall_o              (stall_o)
`endif
  );

  localparam logic [6:0] F_RW  = 7'b1000000;
  localparam logic [6:0] F_WDC = 7'b0100000;
  localparam logic [6:0] F_CBW = 7'b0010000;
  localparam logic [6:0] F_MR  = 7'b0001000;
  localparam logic [6:0] F_MW  = 7'b0000100;
  localparam logic [6:0] F_BF  = 7'b0000010;
  localparam logic [6:0] F_BB  = 7'b0000001;

  int checks = 0;
  int failures = 0;
  logic [24:0] exp_q[$];
  logic [24:0] act;

  assign act = {alucontrol_o, rs_addr_o, rt_addr_o, write_addr_o,
                immediate_o, regwrite_o, write_data_control_o,
                cbwrite_o, memread_o, memwrite_o, branchf_o, branchb_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] v(input logic [3:0] alu,
                                    input logic [2:0] rs,
                                    input logic [2:0] rt,
                                    input logic [2:0] wa,
                                    input logic [4:0] imm,
                                    input logic [6:0] fl);
    return {alu, rs, rt, wa, imm, fl};
  endfunction

  task automatic chk(input string name, input logic [31:0] a,
                     input logic [31:0] r);
    checks++;
    if (a !== r) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, a, r, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [24:0] e, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic issue(input logic [7:0] ins);
    int n;
    n = 0;
    instr_i = ins;
    instr_valid_i = 1'b1;
    #1;
    while (!instr_ready_o && n < 20) begin
      step();
      n++;
    end
    if (!instr_ready_o) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout instr=%h ready=0 required=1", ins);
      instr_valid_i = 1'b0;
    end else begin
      step();
      instr_valid_i = 1'b0;
    end
  endtask

  // monitor: valid cycles pop the scoreboard, idle cycles must be all zero
  initial begin
    forever begin
      @(negedge clk);
      if (ctrl_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual=%h required=none", act);
        end else begin
          chk("ctrl_fields", 32'(act), 32'(exp_q.pop_front()));
        end
      end else begin
        chk("idle_zero", 32'(act), 32'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0;
    instr_i = 8'h00;
    instr_valid_i = 1'b0;
    alu_flag_i = 1'b0;
    mem_ready_i = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    instr_i = 8'h4B;
    instr_valid_i = 1'b1;
    #1;
    chk("rst_ready", 32'(instr_ready_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    chk("rst_cb", 32'(cb_o), 32'd0);
    chk("rst_valid", 32'(ctrl_valid_o), 32'd0);
    instr_valid_i = 1'b0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;

    // add wa=1 rs=3, one-cycle valid pulse
    push(v(4'h1, 3'd3, 3'd7, 3'd1, 5'd0, F_RW), 1);
    issue(8'h4B);
    step();
    chk("add_pulse_end", 32'(ctrl_valid_o), 32'd0);

    // slt with flag=1 then brf: one-cycle interlock, taken branch
    alu_flag_i = 1'b1;
    push(v(4'h5, 3'd6, 3'd7, 3'd0, 5'd0, F_CBW), 1);
    push(v(4'h1, 3'd2, 3'd0, 3'd0, 5'd0, F_BF), 1);
    issue(8'h80);
    instr_i = 8'hF2;
    instr_valid_i = 1'b1;
    #1;
    chk("interlock_ready", 32'(instr_ready_o), 32'd0);
    step();
    chk("interlock_release", 32'(instr_ready_o), 32'd1);
    step();
    instr_valid_i = 1'b0;
    chk("brf_cb", 32'(cb_o), 32'd1);
    alu_flag_i = 1'b0;

    // load r5, ack after three memread cycles
    push(v(4'h1, 3'd0, 3'd7, 3'd5, 5'd0, F_WDC | F_MR), 3);
    push(v(4'h1, 3'd0, 3'd7, 3'd5, 5'd0, F_RW | F_WDC), 1);
    issue(8'h95);
    step();
    step();
    mem_ready_i = 1'b1;
    #1;
    chk("load_ready", 32'(instr_ready_o), 32'd0);
    step();
    mem_ready_i = 1'b0;

    // remaining decode patterns
    push(v(4'h8, 3'd0, 3'd0, 3'd7, 5'h15, F_RW), 1);
    push(v(4'h4, 3'd2, 3'd5, 3'd3, 5'd0, F_RW), 1);
    push(v(4'h2, 3'd4, 3'd7, 3'd4, 5'd0, F_RW), 1);
    push(v(4'h3, 3'd1, 3'd7, 3'd1, 5'd0, F_RW), 1);
    push(v(4'h6, 3'd1, 3'd0, 3'd1, 5'd0, F_RW), 1);
    push(v(4'h9, 3'd6, 3'd7, 3'd7, 5'd0, F_RW), 1);
    push(v(4'h7, 3'd3, 3'd7, 3'd0, 5'd0, F_CBW), 1);
    push(v(4'h1, 3'd4, 3'd0, 3'd0, 5'd0, 7'd0), 1);
    issue(8'hD5);
    issue(8'hFB);
    issue(8'hE4);
    issue(8'hE9);
    issue(8'hA1);
    issue(8'hBE);
    issue(8'hAB);
    issue(8'hB4);
    chk("seq_cb_clear", 32'(cb_o), 32'd0);

    // halt, restart, then an and is accepted
    push(25'd0, 1);
    issue(8'h88);
    chk("halt_done", 32'(done_o), 32'd1);
    instr_i = 8'h0A;
    instr_valid_i = 1'b1;
    #1;
    chk("halt_ready", 32'(instr_ready_o), 32'd0);
    step();
    chk("halt_hold", 32'(done_o), 32'd1);
    push(v(4'h0, 3'd2, 3'd7, 3'd1, 5'd0, F_RW), 1);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("restart_done", 32'(done_o), 32'd0);
    issue(8'h0A);

    // store with no ack: sixteen memwrite cycles then sticky fault
    push(v(4'h1, 3'd2, 3'd7, 3'd0, 5'd0, F_MW), 16);
    issue(8'h9A);
    for (int i = 0; i < 15; i++) step();
    chk("store_pre_fault", 32'(fault_o), 32'd0);
    step();
    chk("store_fault", 32'(fault_o), 32'd1);
    instr_i = 8'h4B;
    instr_valid_i = 1'b1;
    #1;
    chk("fault_ready", 32'(instr_ready_o), 32'd0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    chk("fault_sticky", 32'(fault_o), 32'd1);
    chk("fault_ready2", 32'(instr_ready_o), 32'd0);
    instr_valid_i = 1'b0;

    // reset clears fault
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("fault_cleared", 32'(fault_o), 32'd0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;

    // set CB, then reset in the middle of a load wait
    alu_flag_i = 1'b1;
    push(v(4'h5, 3'd6, 3'd7, 3'd0, 5'd0, F_CBW), 1);
    issue(8'h80);
    step();
    chk("cb_set", 32'(cb_o), 32'd1);
    alu_flag_i = 1'b0;
    push(v(4'h1, 3'd0, 3'd7, 3'd5, 5'd0, F_WDC | F_MR), 2);
    issue(8'h95);
    step();
    #5;
    chk("mem_wait_read", 32'(memread_o), 32'd1);
    rst_n = 1'b0;
    instr_valid_i = 1'b1;
    #1;
    chk("abort_memread", 32'(memread_o), 32'd0);
    chk("abort_valid", 32'(ctrl_valid_o), 32'd0);
    chk("abort_cb", 32'(cb_o), 32'd0);
    chk("abort_idle", 32'(instr_ready_o), 32'd0);
    step();
    step();
    instr_valid_i = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_after_rst", 32'(instr_ready_o), 32'd0);
    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
